// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and the PWM compare function for the 16-channel PWM
//   output stage.
//   PWM_CNT_W : width of the PWM period counter and of the duty value
//   DUTY_FULL : duty code that forces a constant-high waveform
//   NUM_CH    : number of output channels (uo_out + uio_out)
//   pwm_level : waveform level for a given counter position and duty
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package pwm_pkg;

  localparam int         PWM_CNT_W = 8;
  localparam logic [7:0] DUTY_FULL = 8'hFF;
  localparam int         NUM_CH    = 16;

  // 0x00 gives a constant low; 0xFF is special-cased to a constant high so the
  // full-scale code really is 100% rather than 255/256.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_if
//   Bundles the SPI register-file side of the PWM stage (enables, mode
//   selects, duty) together with the pad-facing outputs.
//   master : register file / pad side - drives the registers, observes outputs
//   slave  : pwm_peripheral - reads the registers, drives the outputs
//   period_start exists only when PWM_PERIOD_PULSE_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pwm_peripheral_if import pwm_pkg::*; ();

  logic [7:0]           en_reg_out_7_0;
  logic [7:0]           en_reg_out_15_8;
  logic [7:0]           en_reg_pwm_7_0;
  logic [7:0]           en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;
  logic [7:0]           uo_out;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;

`ifdef PWM_PERIOD_PULSE_EN
  logic                 period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  uo_out, uio_out, uio_oe, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output uo_out, uio_out, uio_oe, period_start
  );
`else
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output uo_out, uio_out, uio_oe
  );
`endif

endinterface

// File: rtl/pwm_in_sync.sv
// -----------------------------------------------------------------------------
// pwm_in_sync
//   Brings an SPI-domain register bus into the clk domain. Two flop stages
//   (s1, s2) are followed by a stability filter: the committed value q only
//   updates when both stages agree, so a bus caught mid-update (or one that
//   keeps changing) is never committed as a torn mixture of bits.
//   A stable change on d appears on q at the third clk edge.
// Ports
//   clk    in   1      system clock
//   rst_n  in   1      asynchronous active-low reset
//   d      in   WIDTH  SPI-domain bus
//   q      out  WIDTH  committed clk-domain value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // NOTE: non-blocking assignments make s1 -> s2 -> q a true shift chain;
  // blocking ones would collapse the stages into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s1 == s2) begin
        q <= s2;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   16-channel PWM output stage. Register-file inputs are synchronised into
//   the clk domain, one shared 8-bit PWM waveform is generated, and each
//   channel is driven off, static high or PWM.
//   Period = 256 * CLK_DIV clk cycles.
// Parameters
//   CLK_DIV  clk cycles per PWM count step (>= 1)
// Ports
//   clk    in   1   system clock
//   rst_n  in   1   asynchronous active-low reset
//   bus    slave    pwm_peripheral_if: en_reg_out_*, en_reg_pwm_*,
//                   pwm_duty_cycle in; uo_out, uio_out, uio_oe out
// Configuration
//   PWM_PERIOD_PULSE_EN : adds bus.period_start, a registered one-cycle pulse
//                         coinciding with the first cnt == 0 cycle of a period.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_peripheral import pwm_pkg::*; #(
  parameter int CLK_DIV = 3000
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_peripheral_if.slave bus
);

  localparam int                 PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PWM_CNT_W-1:0] CNT_LAST = '1;

  // ---------------------------------------------------------------------------
  // Register synchronisers
  // ---------------------------------------------------------------------------
  logic [7:0]           q_out_lo;
  logic [7:0]           q_out_hi;
  logic [7:0]           q_pwm_lo;
  logic [7:0]           q_pwm_hi;
  logic [PWM_CNT_W-1:0] q_duty;

  pwm_in_sync #(.WIDTH(8)) u_sync_out_lo (
    .clk(clk), .rst_n(rst_n), .d(bus.en_reg_out_7_0),  .q(q_out_lo)
  );
  pwm_in_sync #(.WIDTH(8)) u_sync_out_hi (
    .clk(clk), .rst_n(rst_n), .d(bus.en_reg_out_15_8), .q(q_out_hi)
  );
  pwm_in_sync #(.WIDTH(8)) u_sync_pwm_lo (
    .clk(clk), .rst_n(rst_n), .d(bus.en_reg_pwm_7_0),  .q(q_pwm_lo)
  );
  pwm_in_sync #(.WIDTH(8)) u_sync_pwm_hi (
    .clk(clk), .rst_n(rst_n), .d(bus.en_reg_pwm_15_8), .q(q_pwm_hi)
  );
  pwm_in_sync #(.WIDTH(PWM_CNT_W)) u_sync_duty (
    .clk(clk), .rst_n(rst_n), .d(bus.pwm_duty_cycle),  .q(q_duty)
  );

  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;

  assign en_out = {q_out_hi, q_out_lo};
  assign en_pwm = {q_pwm_hi, q_pwm_lo};

  // ---------------------------------------------------------------------------
  // Prescaler and period counter
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]     pre;
  logic                 tick;
  logic [PWM_CNT_W-1:0] cnt;
  logic                 wrap;

  assign tick = (pre == PRE_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + PWM_CNT_W'(1);
    end
  end

  // Duty is shadowed at the period wrap so a write never reshapes a period
  // that is already running.
  logic [PWM_CNT_W-1:0] duty_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh <= '0;
    end else if (wrap) begin
      duty_sh <= q_duty;
    end
  end

  logic level;
  assign level = pwm_level(cnt, duty_sh);

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] ch_out;
  logic [7:0]        oe;

  // Per channel: en_out ? (en_pwm ? level : 1) : 0, written as a mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out <= '0;
    end else begin
      ch_out <= en_out & (~en_pwm | {NUM_CH{level}});
    end
  end

  // Pads are outputs-only once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe <= 8'h00;
    end else begin
      oe <= 8'hFF;
    end
  end

  assign bus.uo_out  = ch_out[7:0];
  assign bus.uio_out = ch_out[15:8];
  assign bus.uio_oe  = oe;

`ifdef PWM_PERIOD_PULSE_EN
  // Registered from the wrap condition, so it is high exactly while cnt == 0
  // first appears.
  logic period_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= wrap;
    end
  end

  assign bus.period_start = period_start_q;
`endif

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Scoreboard bench for pwm_peripheral with CLK_DIV = 4 (period 1024 clk).
//   Stimulus pushes hand-computed expectations tagged with the clk cycle at
//   which they hold; a monitor records uo_out every cycle on the falling edge
//   and pops and compares entries as their cycle arrives. Window entries
//   compare the number of high cycles of channel 0 over a span, and require
//   every other channel to stay low over that span.
//   Cycle arithmetic: with the edges after reset release numbered 1, 2, ...,
//   cnt after edge m is (m / 4) mod 256, and the output sampled after edge n
//   reflects cnt/duty as they stood after edge n-1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int HIST_N  = 16384;
  localparam int MAX_CYC = 20000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_peripheral_if bus_if ();

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    bit    win;
    int    len;
    int    uo;
    int    uio;
    int    oe;
    int    hi;
    string name;
  } exp_t;

  exp_t sb[$];

  int tcyc     = 0;
  int base     = 0;
  int n_checks = 0;
  int n_fail   = 0;

  bit hist_hi  [HIST_N];
  bit hist_oth [HIST_N];

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, tcyc);
    end
  endtask

  task automatic exp_sample(input string name, input int cyc,
                            input int uo, input int uio, input int oe);
    exp_t e;
    e.cyc = cyc; e.win = 1'b0; e.len = 0;
    e.uo = uo; e.uio = uio; e.oe = oe; e.hi = 0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_window(input string name, input int end_cyc,
                            input int len, input int hi);
    exp_t e;
    e.cyc = end_cyc; e.win = 1'b1; e.len = len;
    e.uo = 0; e.uio = 0; e.oe = 0; e.hi = hi; e.name = name;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (tcyc < HIST_N) begin
        hist_hi[tcyc]  = bus_if.uo_out[0];
        hist_oth[tcyc] = (bus_if.uo_out[7:1] != 7'd0) || (bus_if.uio_out != 8'd0);
      end
      while (sb.size() > 0 && sb[0].cyc <= tcyc) begin
        exp_t e;
        int   n_hi;
        int   n_oth;
        e = sb.pop_front();
        if (e.cyc < tcyc) begin
          check({e.name, "_late"}, tcyc, e.cyc);
        end else if (!e.win) begin
          check({e.name, "_uo"},  int'(bus_if.uo_out),  e.uo);
          check({e.name, "_uio"}, int'(bus_if.uio_out), e.uio);
          check({e.name, "_oe"},  int'(bus_if.uio_oe),  e.oe);
        end else begin
          n_hi  = 0;
          n_oth = 0;
          for (int k = e.cyc - e.len + 1; k <= e.cyc; k++) begin
            if (k >= 0 && k < HIST_N) begin
              n_hi  += int'(hist_hi[k]);
              n_oth += int'(hist_oth[k]);
            end
          end
          check({e.name, "_ch0_high_cycles"}, n_hi, e.hi);
          check({e.name, "_other_ch_high_cycles"}, n_oth, 0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    wait (tcyc >= MAX_CYC);
    $display("FAIL watchdog: cycle %0d reached limit %0d", tcyc, MAX_CYC);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep,
                          input logic [7:0] duty);
    bus_if.en_reg_out_7_0  = eo[7:0];
    bus_if.en_reg_out_15_8 = eo[15:8];
    bus_if.en_reg_pwm_7_0  = ep[7:0];
    bus_if.en_reg_pwm_15_8 = ep[15:8];
    bus_if.pwm_duty_cycle  = duty;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int n);
    while (tcyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held with random register contents.
    rst_n = 1'b0;
    set_regs(16'($urandom), 16'($urandom), 8'($urandom));
    step(2);
    exp_sample("rst_hold_a", tcyc + 1, 0, 0, 0);
    exp_sample("rst_hold_b", tcyc + 2, 0, 0, 0);
    set_regs(16'($urandom), 16'($urandom), 8'($urandom));
    step(3);

    // Release; uio_oe follows on the next edge.
    rst_n = 1'b1;
    set_regs(16'h0000, 16'h0000, 8'h00);
    base = tcyc;
    exp_sample("oe_before_edge", base,     0, 0, 8'h00);
    exp_sample("oe_after_edge",  base + 1, 0, 0, 8'hFF);

    // All channels static high: 3 edges to commit, 1 to register.
    wait_rel(10);
    set_regs(16'hFFFF, 16'h0000, 8'h00);
    exp_sample("static_not_yet", base + 13, 8'h00, 8'h00, 8'hFF);
    exp_sample("static_on",      base + 14, 8'hFF, 8'hFF, 8'hFF);
    exp_sample("static_hold",    base + 19, 8'hFF, 8'hFF, 8'hFF);

    // Ch0 PWM at 50%; duty loads at the wrap on edge 1024.
    wait_rel(20);
    set_regs(16'h0001, 16'h0001, 8'h80);
    exp_sample("d80_before_wrap", base + 1024, 8'h00, 8'h00, 8'hFF);
    exp_sample("d80_first_high",  base + 1025, 8'h01, 8'h00, 8'hFF);
    exp_sample("d80_last_high",   base + 1536, 8'h01, 8'h00, 8'hFF);
    exp_sample("d80_first_low",   base + 1537, 8'h00, 8'h00, 8'hFF);
    exp_window("d80_period1",     base + 2048, 1024, 512);
    exp_window("d80_period2",     base + 3072, 1024, 512);

    // Duty 0x00 -> constant low for the period starting at edge 4096.
    wait_rel(3100);
    set_regs(16'h0001, 16'h0001, 8'h00);
    exp_window("d00_period", base + 5120, 1024, 0);

    // Duty 0xFF -> constant high for two full periods from edge 6144.
    wait_rel(5200);
    set_regs(16'h0001, 16'h0001, 8'hFF);
    exp_window("dff_two_periods", base + 8192, 2048, 2048);

    // Duty 0x40 loads at edge 9216; 0xC0 written mid-period must wait.
    wait_rel(8200);
    set_regs(16'h0001, 16'h0001, 8'h40);
    exp_sample("d40_last_high",  base + 9472, 8'h01, 8'h00, 8'hFF);
    exp_sample("d40_first_low",  base + 9473, 8'h00, 8'h00, 8'hFF);
    exp_window("d40_period",     base + 10240, 1024, 256);
    wait_rel(9500);
    set_regs(16'h0001, 16'h0001, 8'hC0);
    exp_sample("dc0_first_high", base + 10241, 8'h01, 8'h00, 8'hFF);
    exp_window("dc0_period",     base + 11264, 1024, 768);

    // Enable bus toggling every cycle must never commit.
    wait_rel(11300);
    exp_window("toggle_no_commit", base + 11330, 40, 40);
    for (int k = 0; k < 20; k++) begin
      bus_if.en_reg_out_7_0 = k[0] ? 8'hAA : 8'h55;
      step(1);
    end
    bus_if.en_reg_out_7_0 = 8'h01;

    // Reset pulse mid-period: restart with cnt = 0 and duty_sh = 0.
    wait_rel(11700);
    rst_n = 1'b0;
    exp_sample("rst_mid_period", tcyc, 0, 0, 0);
    step(3);
    rst_n = 1'b1;
    base = tcyc;
    exp_sample("restart_oe",        base + 1,    8'h00, 8'h00, 8'hFF);
    exp_window("restart_low_until_wrap", base + 1024, 1020, 0);
    exp_sample("restart_first_high", base + 1025, 8'h01, 8'h00, 8'hFF);
    exp_window("restart_period",    base + 2048, 1024, 768);

    wait_rel(2050);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
